serial_alu: RTL

//  Bit-serial W-bit ALU built from one 1-bit ALU slice reused every clock; LSB first, carry held in a flop.

---
 rtl/serial_alu_pkg.sv | 38 +++
 rtl/serial_alu_if.sv | 27 ++
 rtl/serial_alu_bitcell.sv | 28 ++
 rtl/serial_alu.sv | 136 +++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
// Shared opcode constants, FSM state encoding and opcode decode helpers for serial_alu.
// Optional SLT support is controlled by the SERIAL_ALU_SLT_EN macro.
package serial_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic op_is_arith(input logic [2:0] op);
`ifdef SERIAL_ALU_SLT_EN
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
`else
        return (op == OP_ADD) || (op == OP_SUB);
`endif
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || op_is_arith(op);
    endfunction

    // Subtraction is A + ~B + 1: invert B in the slice and seed the carry with 1.
    function automatic logic op_inv_b(input logic [2:0] op);
`ifdef SERIAL_ALU_SLT_EN
        return (op == OP_SUB) || (op == OP_SLT);
`else
        return (op == OP_SUB);
`endif
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Request/response bus of the bit-serial ALU: operand handshake in, result handshake out.
interface serial_alu_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic         co;
    logic         ovf;
    logic         zero;
    logic         err;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, r, co, ovf, zero, err
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, r, co, ovf, zero, err
    );
endinterface

// File: rtl/serial_alu_bitcell.sv
// Combinational 1-bit ALU slice: AND, OR, or full add with optional B inversion.
module serial_alu_bitcell
    import serial_alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ci_i,
    input  logic [2:0] op_i,
    output logic       r_o,
    output logic       co_o
);
    logic b_eff;

    assign b_eff = b_i ^ op_inv_b(op_i);

    always_comb begin
        r_o  = 1'b0;
        co_o = 1'b0;
        if (op_i == OP_AND) begin
            r_o = a_i & b_i;
        end else if (op_i == OP_OR) begin
            r_o = a_i | b_i;
        end else if (op_is_arith(op_i)) begin
            r_o  = a_i ^ b_eff ^ ci_i;
            co_o = (a_i & b_eff) | (a_i & ci_i) | (b_eff & ci_i);
        end
    end
endmodule

// File: rtl/serial_alu.sv
// Bit-serial W-bit ALU: one 1-bit slice reused each clock, LSB first, carry kept in a flop.
// Define SERIAL_ALU_SLT_EN to enable op 111 (signed set-less-than); otherwise it is illegal.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_alu_if.slave   bus
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [2:0]    op_q, op_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  r_q, r_d;
    logic          co_q, co_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;

    logic slice_r;
    logic slice_co;
    logic msb_ovf;

    serial_alu_bitcell u_bitcell (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (carry_q),
        .op_i (op_q),
        .r_o  (slice_r),
        .co_o (slice_co)
    );

    // Only meaningful on the last bit, where carry_q is the carry into the MSB.
    assign msb_ovf = carry_q ^ slice_co;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            carry_q <= 1'b0;
            r_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            r_q     <= r_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        r_d     = r_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    carry_d = op_inv_b(bus.op);
                    r_d     = '0;
                    co_d    = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = slice_co;
                r_d     = {slice_r, r_q[W-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_is_legal(op_q)) begin
                        r_d   = '0;
                        err_d = 1'b1;
                    end
`ifdef SERIAL_ALU_SLT_EN
                    else if (op_q == OP_SLT) begin
                        // slice_r is the sign of A-B; sign^ovf gives the true signed compare.
                        r_d = {{(W-1){1'b0}}, slice_r ^ msb_ovf};
                    end
`endif
                    else if (op_is_arith(op_q)) begin
                        co_d  = slice_co;
                        ovf_d = msb_ovf;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.r         = r_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = (r_q == '0);
    assign bus.err       = err_q;
endmodule
